// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 7-segment driver: scans NUM_DIGITS digits from a per-frame snapshot,
// with anti-ghost blanking at the start of each slot, per-digit blink and a frame_start strobe.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int DISP_WIDTH   = 8,
    parameter int SCAN_DIV     = 12500,
    parameter int BLANK_CYCLES = 250,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [5*NUM_DIGITS-1:0] codes,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blink,
    input  logic                    mask_mode,
    output logic [DISP_WIDTH-1:0]   disps,
    output logic [7:0]              digital_leds,
    output logic                    frame_start
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int POS_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]                r_cnt;
    logic [POS_W-1:0]                r_pos;
    logic [FRM_W-1:0]                r_frameCnt;
    logic                            r_phase;
    logic [NUM_DIGITS-1:0][4:0]      r_snapCodes;
    logic [NUM_DIGITS-1:0]           r_snapDp;
    logic [NUM_DIGITS-1:0]           r_snapBlink;
    logic                            r_snapMask;
    logic [DISP_WIDTH-1:0]           r_disps;
    logic [7:0]                      r_leds;
    logic                            r_frameStart;

    logic                            w_slotEnd;
    logic                            w_frameEnd;
    logic [4:0]                      w_code;
    logic                            w_digitOff;
    logic [6:0]                      w_glyph;
    logic [DISP_WIDTH-1:0]           w_nextDisps;
    logic [7:0]                      w_nextLeds;

    function automatic logic [6:0] hexGlyph(input logic [3:0] value);
        case (value)
            4'h0:    hexGlyph = 7'h3f;
            4'h1:    hexGlyph = 7'h06;
            4'h2:    hexGlyph = 7'h5b;
            4'h3:    hexGlyph = 7'h4f;
            4'h4:    hexGlyph = 7'h66;
            4'h5:    hexGlyph = 7'h6d;
            4'h6:    hexGlyph = 7'h7d;
            4'h7:    hexGlyph = 7'h07;
            4'h8:    hexGlyph = 7'h7f;
            4'h9:    hexGlyph = 7'h6f;
            4'ha:    hexGlyph = 7'h77;
            4'hb:    hexGlyph = 7'h7c;
            4'hc:    hexGlyph = 7'h39;
            4'hd:    hexGlyph = 7'h5e;
            4'he:    hexGlyph = 7'h79;
            default: hexGlyph = 7'h71;
        endcase
    endfunction

    // Decode works purely from registered state so the outputs lag it by exactly one cycle.
    always_comb begin
        w_slotEnd   = (r_cnt == CNT_LAST);
        w_frameEnd  = w_slotEnd && (r_pos == POS_LAST);
        w_code      = r_snapCodes[r_pos];
        w_digitOff  = (r_cnt < BLANK_END) || w_code[4] || (r_snapBlink[r_pos] && r_phase);
        w_glyph     = r_snapMask ? 7'h40 : hexGlyph(w_code[3:0]);
        w_nextDisps = '1;
        w_nextLeds  = '0;
        if (!w_digitOff) begin
            w_nextDisps = ~(DISP_WIDTH'(1) << r_pos);
            w_nextLeds  = {r_snapDp[r_pos], w_glyph};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_pos        <= '0;
            r_frameCnt   <= '0;
            r_phase      <= 1'b0;
            r_snapCodes  <= {NUM_DIGITS{5'h10}};
            r_snapDp     <= '0;
            r_snapBlink  <= '0;
            r_snapMask   <= 1'b0;
            r_disps      <= '1;
            r_leds       <= '0;
            r_frameStart <= 1'b0;
        end else begin
            if (w_slotEnd) begin
                r_cnt <= '0;
                r_pos <= (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Inputs are captured only here, so a frame never mixes old and new digits.
            if (w_frameEnd) begin
                r_snapCodes <= codes;
                r_snapDp    <= dp;
                r_snapBlink <= blink;
                r_snapMask  <= mask_mode;
                if (r_frameCnt == FRM_LAST) begin
                    r_frameCnt <= '0;
                    r_phase    <= ~r_phase;
                end else begin
                    r_frameCnt <= r_frameCnt + 1'b1;
                end
            end

            r_frameStart <= w_frameEnd;
            r_disps      <= w_nextDisps;
            r_leds       <= w_nextLeds;
        end
    end

    assign disps        = r_disps;
    assign digital_leds = r_leds;
    assign frame_start  = r_frameStart;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: table-driven frames, directed corner cases and
// randomized inputs compared against a frame/slot arithmetic reference model.
module tb_seven_seg_scanner;

    localparam int ND = 4;
    localparam int DW = 8;
    localparam int SD = 4;
    localparam int BL = 1;
    localparam int BF = 2;
    localparam int FL = ND * SD;
    localparam int MAX_FRAMES = 512;

    typedef struct packed {
        logic [19:0] codes;
        logic [3:0]  dp;
        logic [3:0]  blink;
        logic        mask;
    } snap_t;

    typedef struct packed {
        logic [19:0]     codes;
        logic [3:0]      dp;
        logic            mask;
        logic [3:0][7:0] expDisps;
        logic [3:0][7:0] expLeds;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [19:0]   codes = '0;
    logic [3:0]    dp = '0;
    logic [3:0]    blink = '0;
    logic          maskMode = 1'b0;
    logic [DW-1:0] disps;
    logic [7:0]    leds;
    logic          frameStart;

    int    total = 0;
    int    bad = 0;
    int    k = 0;
    snap_t snaps [MAX_FRAMES];
    vec_t  vecs [3];
    logic [6:0] glyphs [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                                7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};

    seven_seg_scanner #(
        .NUM_DIGITS(ND), .DISP_WIDTH(DW), .SCAN_DIV(SD), .BLANK_CYCLES(BL), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .codes(codes), .dp(dp), .blink(blink),
        .mask_mode(maskMode), .disps(disps), .digital_leds(leds), .frame_start(frameStart)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
        end
    endtask

    // k counts active edges since reset; the output after edge k reflects frame (k-1)/FL.
    task automatic modelExpect(output logic [7:0] eDisps, output logic [7:0] eLeds, output logic eFs);
        int m, c, p, f;
        snap_t s;
        logic [4:0] code;
        eDisps = 8'hFF;
        eLeds  = 8'h00;
        eFs    = 1'b0;
        if (k == 0) return;
        eFs = (k % FL == 0);
        m = k - 1;
        c = m % SD;
        p = (m / SD) % ND;
        f = m / FL;
        if (f == 0 || f >= MAX_FRAMES) return;
        s = snaps[f];
        code = s.codes[p*5 +: 5];
        if (c < BL || code[4] || (s.blink[p] && ((f / BF) % 2 == 1))) return;
        eDisps = ~(8'd1 << p);
        eLeds  = {s.dp[p], s.mask ? 7'h40 : glyphs[code[3:0]]};
    endtask

    task automatic checkOutput();
        logic [7:0] eDisps, eLeds;
        logic eFs;
        modelExpect(eDisps, eLeds, eFs);
        checkValue("model disps", disps, eDisps);
        checkValue("model leds", leds, eLeds);
        checkValue("model frame_start", {7'd0, frameStart}, {7'd0, eFs});
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        if (!rst_n) begin
            k = 0;
        end else begin
            k++;
            if (k % FL == 0 && k / FL < MAX_FRAMES)
                snaps[k / FL] = '{codes: codes, dp: dp, blink: blink, mask: maskMode};
        end
        @(negedge clk);
        checkOutput();
    endtask

    task automatic randomInputs();
        codes    = 20'($urandom);
        dp       = 4'($urandom);
        blink    = 4'($urandom);
        maskMode = ($urandom_range(0, 3) == 0);
    endtask

    task automatic waitFrameStart();
        int n = 1;
        applyStimulus();
        while (!frameStart && n < 40) begin
            applyStimulus();
            n++;
        end
        checkValue("frame_start wait", {7'd0, frameStart}, 8'd1);
    endtask

    initial begin
        int litCount;
        vecs[0] = '{codes: {5'h03, 5'h02, 5'h01, 5'h00}, dp: 4'b0100, mask: 1'b0,
                    expDisps: {8'hF7, 8'hFB, 8'hFD, 8'hFE}, expLeds: {8'h4f, 8'hdb, 8'h06, 8'h3f}};
        vecs[1] = '{codes: {5'h10, 5'h02, 5'h01, 5'h00}, dp: 4'b0000, mask: 1'b1,
                    expDisps: {8'hFF, 8'hFB, 8'hFD, 8'hFE}, expLeds: {8'h00, 8'h40, 8'h40, 8'h40}};
        vecs[2] = '{codes: {5'h0F, 5'h0C, 5'h0A, 5'h0E}, dp: 4'b1001, mask: 1'b0,
                    expDisps: {8'hF7, 8'hFB, 8'hFD, 8'hFE}, expLeds: {8'hf1, 8'h39, 8'h77, 8'hf9}};

        // Reset with random inputs, then the all-blank first frame.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            randomInputs();
            applyStimulus();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            randomInputs();
            applyStimulus();
            checkValue("first frame disps", disps, 8'hFF);
            checkValue("first frame leds", leds, 8'h00);
            checkValue("first frame_start", {7'd0, frameStart}, (i == 15) ? 8'd1 : 8'd0);
        end

        blink = '0;
        for (int v = 0; v < 3; v++) begin
            codes    = vecs[v].codes;
            dp       = vecs[v].dp;
            maskMode = vecs[v].mask;
            waitFrameStart();
            for (int j = 0; j < 16; j++) begin
                applyStimulus();
                checkValue($sformatf("vec%0d disps", v), disps,
                           (j % 4 == 0) ? 8'hFF : vecs[v].expDisps[j / 4]);
                checkValue($sformatf("vec%0d leds", v), leds,
                           (j % 4 == 0) ? 8'h00 : vecs[v].expLeds[j / 4]);
            end
        end

        // Mid-frame input change must not reach the display until the next snapshot.
        codes = {4{5'h05}};
        dp = '0;
        maskMode = 1'b0;
        waitFrameStart();
        repeat (2) applyStimulus();
        checkValue("snapshot old", leds, 8'h6d);
        repeat (4) applyStimulus();
        codes = {4{5'h09}};
        repeat (10) applyStimulus();
        checkValue("snapshot held", leds, 8'h6d);
        checkValue("snapshot fs", {7'd0, frameStart}, 8'd1);
        repeat (2) applyStimulus();
        checkValue("snapshot new", leds, 8'h6f);

        // Blink only digit 0; over any four frames it is lit for exactly two.
        codes = {4{5'h08}};
        blink = 4'b0001;
        waitFrameStart();
        litCount = 0;
        for (int fr = 0; fr < 4; fr++) begin
            for (int j = 0; j < 16; j++) begin
                applyStimulus();
                if (j == 1 && leds == 8'h7f) litCount++;
                if (j == 5 || j == 9 || j == 13)
                    checkValue("unblinked digit", leds, 8'h7f);
            end
        end
        checkValue("blink lit frames", 8'(litCount), 8'd2);

        for (int i = 0; i < 400; i++) begin
            randomInputs();
            applyStimulus();
        end

        // Reset asserted during slot 2 of a visible frame.
        codes = {5'h03, 5'h02, 5'h01, 5'h00};
        dp = 4'b1111;
        blink = '0;
        maskMode = 1'b0;
        waitFrameStart();
        repeat (10) applyStimulus();
        checkValue("pre-reset disps", disps, 8'hFB);
        rst_n = 1'b0;
        applyStimulus();
        checkValue("mid reset disps", disps, 8'hFF);
        checkValue("mid reset leds", leds, 8'h00);
        checkValue("mid reset fs", {7'd0, frameStart}, 8'd0);
        repeat (2) applyStimulus();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            if (i < 16) checkValue("restart blank", disps, 8'hFF);
            if (i == 15) checkValue("restart fs", {7'd0, frameStart}, 8'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Parametrised time-multiplexed 7-segment driver for the safe-box front panel.
- Scans NUM_DIGITS digits out of a DISP_WIDTH-wide common-anode enable bus.
- Each digit carries a 5-bit code: bit 4 means blank, bits 3:0 are a hex value. Each digit also has a decimal point and a blink flag.
- Adds a per-frame input snapshot (tear-free), an anti-ghost blanking interval, per-digit blink, and a frame_start strobe for upstream handshaking.

Parameters:
- NUM_DIGITS, 4, digits scanned; legal range 1..DISP_WIDTH.
- DISP_WIDTH, 8, width of the disps enable bus; unused enables are held high.
- SCAN_DIV, 12500, clk cycles per digit slot; must be at least 2.
- BLANK_CYCLES, 250, cycles at the start of each slot with everything off; must be less than SCAN_DIV (0 is legal).
- BLINK_FRAMES, 250, frames per blink half-period; must be at least 1.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  synchronous, active-low reset.
- codes  in  5*NUM_DIGITS  digit i occupies bits [5i+4:5i]; bit 4 set means blank.
- dp  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- blink  in  NUM_DIGITS  per-digit blink enable.
- mask_mode  in  1  1 = show '-' (8'h40 pattern) instead of the hex glyph.
- disps  out  DISP_WIDTH  digit enables, active-low, registered.
- digital_leds  out  8  segments, active-high, registered; bit 7 = dp, bits 6:0 = gfedcba.
- frame_start  out  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset: rst_n sampled low at a rising edge of clk gives the following reset state.
  - Counters: cnt=0, pos=0, frame_cnt=0, phase=0.
  - Snapshot: every snapshot code = 5'h10 (blank); snapshot dp/blink/mask = 0.
  - Outputs: disps all 1, digital_leds = 0, frame_start = 0.
  - Reset mid-frame aborts the scan immediately; no partial output persists.
- Slot timing:
  - cnt counts 0..SCAN_DIV-1.
  - On cnt==SCAN_DIV-1, cnt wraps to 0 and pos advances, wrapping NUM_DIGITS-1 to 0.
- Frame end: the condition E = (cnt==SCAN_DIV-1 && pos==NUM_DIGITS-1).
  - On E, codes/dp/blink/mask_mode are copied into the snapshot registers.
  - frame_start is registered from E, so it is high exactly on the cycle the new snapshot is first visible.
  - The first frame after reset therefore displays all blank.
- Blink:
  - On E, frame_cnt increments.
  - When frame_cnt==BLINK_FRAMES-1 on E, frame_cnt clears and phase toggles.
- Output decode uses registered state (cnt, pos, snapshot) at edge t and appears at t+1, i.e. one cycle of latency. A digit is off when any of these holds:
  - cnt < BLANK_CYCLES, or
  - the snapshot code bit 4 is set, or
  - the snapshot blink bit is set and phase==1.
- When the digit is off: disps all 1 and digital_leds = 0.
- Otherwise: disps[pos]=0 and all other bits 1.
  - digital_leds[6:0] = 7'h40 if mask_mode, else the hex glyph 3f,06,5b,4f,66,6d,7d,07,7f,6f,77,7c,39,5e,79,71 for 0..F.
  - digital_leds[7] = the snapshot dp bit.
- disps bits NUM_DIGITS..DISP_WIDTH-1 are always 1.
- Inputs may change at any time; only values present in the E cycle are displayed during the next frame.
- Counter widths: cnt uses clog2(SCAN_DIV) bits; frame_cnt uses clog2(BLINK_FRAMES+1) bits; no overflow is possible.
- NUM_DIGITS=1: pos stays 0 and E fires on every cnt wrap.

Test Plan:
- Common setup for all tests: NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2.
- Reset: hold rst_n low 3 cycles with random inputs, then release.
  - Required: disps=8'hFF and digital_leds=0 throughout the first 16 cycles after release.
  - Required: frame_start pulses once, 16 cycles after release.
- Hex scan: codes={5'h03,5'h02,5'h01,5'h00}, dp=4'b0100.
  - Required after frame_start, per 4-cycle slot: one blank cycle (disps=FF, leds=00), then 3 cycles of the slot value.
  - Slot values: FE/3f, FD/06, FB/db (dp set), F7/4f.
- Mask and blank: mask_mode=1, codes[19:15]=5'h10.
  - Required: digits 0-2 show leds=40 with their enables.
  - Required: the digit 3 slot stays at disps=FF, leds=00 for all 4 cycles.
- Snapshot: change codes mid-frame from 5'h05 to 5'h09.
  - Required: the current frame still shows 6d.
  - Required: 9 (6f) appears only after the next frame_start.
- Blink: blink=4'b0001, codes all 5'h08.
  - Required: digit 0 shows 7f for 2 frames, is off for 2 frames, and repeats.
  - Required: digits 1-3 are never blinked.
- Mid-operation reset: assert rst_n=0 during slot 2.
  - Required: the next cycle gives disps=FF, leds=00, frame_start=0.
  - Required: after release, the scan restarts at slot 0 with a blank snapshot.
